lane_stripe_ctrl: RTL and testbench
===================================

# lane_stripe_ctrl

Round-robin byte-striping controller for the PCIe physical-layer transmit path. Accepts one byte per cycle from the upstream byte stream and steers it to one of LANES lane outputs in strict order 0,1,…,LANES-1. Applies per-lane backpressure and pads partial stripes with a PAD symbol on request, so all lanes stay byte-aligned. Sits between the packet byte source and the per-lane demux/serializer stages, and owns the lane selector they share.

## Interface
- LANES, 4, number of lanes; power of two, 2..8
- WIDTH, 8, byte width
- PAD_BYTE, 8'hF7, symbol written to lanes during padding (K23.7 PAD)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_data  in  WIDTH  upstream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted this cycle when in_valid && in_ready (combinational)
- flush  in  1  level; request padding of the current partial stripe
- lane_full  in  LANES  bit k high: lane k cannot take a byte this cycle
- lane_data  out  LANES*WIDTH  lane k byte at [k*WIDTH +: WIDTH]
- lane_valid  out  LANES  one-hot or zero; lane k byte valid
- sel  out  log2(LANES)  current lane pointer
- stripe_done  out  1  pulse: a full stripe (through lane LANES-1) completed
- stripe_cnt  out  16  completed stripes, wraps 16'hFFFF→0
- busy  out  1  state != IDLE

## Operation
- States: IDLE (sel==0, no partial stripe), STRIPE (sel!=0), PAD (filling the remainder of a stripe).
- in_ready = (state != PAD) && !lane_full[sel].
- Accept in IDLE/STRIPE when in_valid && in_ready: lane_data[sel] ← in_data, lane_valid[sel] ← 1, sel ← sel+1 mod LANES.
- Next state after accept: STRIPE if new sel != 0, else IDLE.
- No accept: lane_valid ← 0, all lane_data ← 0. Also every non-written lane has lane_data cleared to 0 in every cycle.
- Target lane full: no write, sel holds. Lanes are never skipped.
- flush sampled each cycle:
  - IDLE: flush is ignored.
  - STRIPE with no accept: go to PAD.
  - STRIPE with an accept in the same cycle: the byte is taken first; go to PAD if the new sel != 0, else IDLE.
- PAD: each cycle with !lane_full[sel], write PAD_BYTE to lane sel and increment sel. Return to IDLE when sel wraps to 0. flush is don't-care in PAD.
- Any write to lane LANES-1 (data or pad): stripe_done ← 1 in the same cycle as that lane_valid, stripe_cnt ← stripe_cnt+1.
- busy = (state != IDLE), registered state decode.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): lane_data=0, lane_valid=0, sel=0, stripe_done=0, stripe_cnt=0, busy=0, state=IDLE.
- in_ready is low while reset is asserted.
- Accept-to-lane_valid latency: 1 cycle. All outputs except in_ready are registered.
- lane_valid and stripe_done are single-cycle pulses per write. Back-to-back accepts give one lane write per cycle.
- Full stripe with no stalls: LANES consecutive cycles.
- PAD with no stalls lasts LANES−sel cycles. in_ready is 0 for the whole PAD period.
- Reset mid-STRIPE or mid-PAD aborts the stripe with no further pad writes. sel returns to 0.
- lane_full on a lane other than lane sel has no effect.

## Test plan
- Reset, then in_valid=1 with bytes 0x10,0x11,0x12,0x13,0x14 (LANES=4).
  - Lanes 0..3 get 0x10..0x13 on consecutive cycles, then lane 0 gets 0x14.
  - stripe_done pulses once with lane_valid[3]; stripe_cnt=1.
- Send 0xA0,0xA1 (sel=2), then flush=1 with in_valid=0.
  - busy=1 and in_ready=0 for 2 cycles.
  - lane2=F7, then lane3=F7 with stripe_done; then IDLE, sel=0.
- lane_full[1]=1 for 3 cycles while in_valid=1 at sel=1.
  - in_ready=0 and no lane_valid for 3 cycles; sel stays 1.
  - The next byte goes to lane 1. lane_full[2] alone at sel=1 causes no stall.
- flush and in_valid together at sel=3 with byte 0x55.
  - Lane 3 gets 0x55, stripe_done pulses, state goes to IDLE with no pad writes.
- Same event at sel=1: lane 1 gets the byte, then lanes 2,3 get F7.
- Assert reset during PAD at sel=2.
  - All outputs 0 immediately, with no further F7 writes.
  - After release, the first byte goes to lane 0 and stripe_cnt=0.
- Drive 65536 full stripes: stripe_cnt wraps to 0.

Source files
------------

// File: rtl/lane_stripe_ctrl.sv
// Round-robin byte striper for the PCIe TX lanes.
// Owns the shared lane selector; pads partial stripes on flush.
module lane_stripe_ctrl #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] PAD_BYTE = 8'hF7,
  localparam int SW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [LANES-1:0]   lane_full,
  output logic [LANES*WIDTH-1:0] lane_data,
  output logic [LANES-1:0]   lane_valid,
  output logic [SW-1:0]      sel,
  output logic               stripe_done,
  output logic [15:0]        stripe_cnt,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    STRIPE,
    PAD
  } state_t;

  state_t state;

  logic             accept;
  logic             pad_wr;
  logic             wr;
  logic             wrap;
  logic [SW-1:0]    sel_nxt;
  logic [WIDTH-1:0] wr_byte;

  assign in_ready = reset && (state != PAD) && !lane_full[sel];
  assign accept   = in_valid && in_ready;
  assign pad_wr   = (state == PAD) && !lane_full[sel];
  assign wr       = accept || pad_wr;
  assign wr_byte  = pad_wr ? PAD_BYTE : in_data;
  assign sel_nxt  = sel + 1'b1;
  assign wrap     = (sel_nxt == '0);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sel         <= '0;
      lane_data   <= '0;
      lane_valid  <= '0;
      stripe_done <= 1'b0;
      stripe_cnt  <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        lane_valid[k] <= wr && (sel == SW'(k));
        lane_data[k*WIDTH +: WIDTH] <=
          (wr && (sel == SW'(k))) ? wr_byte : '0;
      end
      stripe_done <= wr && (sel == SW'(LANES-1));
      if (wr) begin
        sel <= sel_nxt;
        if (sel == SW'(LANES-1))
          stripe_cnt <= stripe_cnt + 16'd1;
      end
      // A byte accepted alongside flush lands first; padding covers the rest
      if (accept) begin
        if (wrap)
          state <= IDLE;
        else if (flush && state == STRIPE)
          state <= PAD;
        else
          state <= STRIPE;
      end else if (pad_wr) begin
        state <= wrap ? IDLE : PAD;
      end else if (flush && state == STRIPE) begin
        state <= PAD;
      end
    end
  end

endmodule

// File: tb/tb_lane_stripe_ctrl.sv
// Directed bench for lane_stripe_ctrl, LANES=4.
// Each task drives one scenario and checks inline.
module tb_lane_stripe_ctrl;

  localparam int LANES = 4;
  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [3:0]  lane_full = '0;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic [1:0]  sel;
  logic        stripe_done;
  logic [15:0] stripe_cnt;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  lane_stripe_ctrl #(
    .LANES(LANES),
    .WIDTH(WIDTH),
    .PAD_BYTE(8'hF7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush(flush),
    .lane_full(lane_full),
    .lane_data(lane_data),
    .lane_valid(lane_valid),
    .sel(sel),
    .stripe_done(stripe_done),
    .stripe_cnt(stripe_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    flush = 1'b0;
    lane_full = '0;
    in_data = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data = 8'hAA;
    reset = 1'b0;
    tick();
    tick();
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 0", in_ready);
    end
    n_chk++;
    if (lane_valid !== 4'h0 || lane_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_lanes: got v=%b d=%h want 0", lane_valid, lane_data);
    end
    n_chk++;
    if (sel !== 2'd0 || busy !== 1'b0 || stripe_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ctl: got sel=%0d busy=%b sd=%b want 0",
               sel, busy, stripe_done);
    end
    n_chk++;
    if (stripe_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_cnt: got %h want 0", stripe_cnt);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_stream();
    logic [3:0]  ev;
    logic [31:0] ed;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'h10 + 8'(i);
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ready%0d: got %b want 1", i, in_ready);
      end
      tick();
      ev = 4'b0001 << (i % 4);
      ed = 32'(8'h10 + 8'(i)) << (8 * (i % 4));
      n_chk++;
      if (lane_valid !== ev || lane_data !== ed) begin
        n_fail++;
        $display("FAIL stream_lane%0d: got v=%b d=%h want v=%b d=%h",
                 i, lane_valid, lane_data, ev, ed);
      end
      n_chk++;
      if (stripe_done !== (i == 3) || sel !== 2'((i + 1) % 4)) begin
        n_fail++;
        $display("FAIL stream_ctl%0d: got sd=%b sel=%0d want sd=%b sel=%0d",
                 i, stripe_done, sel, (i == 3), (i + 1) % 4);
      end
    end
    n_chk++;
    if (stripe_cnt !== 16'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_cnt: got cnt=%0d busy=%b want 1 1",
               stripe_cnt, busy);
    end
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (lane_valid !== 4'h0 || lane_data !== 32'h0) begin
      n_fail++;
      $display("FAIL stream_idle: got v=%b d=%h want 0", lane_valid, lane_data);
    end
  endtask

  task automatic test_flush_pad();
    apply_reset();
    send(8'hA0);
    send(8'hA1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || lane_valid !== 4'h0) begin
      n_fail++;
      $display("FAIL pad_enter: got busy=%b rdy=%b v=%b want 1 0 0",
               busy, in_ready, lane_valid);
    end
    tick();
    n_chk++;
    if (lane_valid !== 4'b0100 || lane_data !== 32'h00F7_0000) begin
      n_fail++;
      $display("FAIL pad_lane2: got v=%b d=%h want 0100 00f70000",
               lane_valid, lane_data);
    end
    n_chk++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || stripe_done !== 1'b0) begin
      n_fail++;
      $display("FAIL pad_mid: got busy=%b rdy=%b sd=%b want 1 0 0",
               busy, in_ready, stripe_done);
    end
    tick();
    n_chk++;
    if (lane_valid !== 4'b1000 || lane_data !== 32'hF700_0000
        || stripe_done !== 1'b1) begin
      n_fail++;
      $display("FAIL pad_lane3: got v=%b d=%h sd=%b want 1000 f7000000 1",
               lane_valid, lane_data, stripe_done);
    end
    n_chk++;
    if (busy !== 1'b0 || sel !== 2'd0 || stripe_cnt !== 16'd1
        || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pad_exit: got busy=%b sel=%0d cnt=%0d rdy=%b want 0 0 1 1",
               busy, sel, stripe_cnt, in_ready);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    send(8'h20);
    in_valid = 1'b1;
    in_data = 8'h21;
    lane_full = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready%0d: got %b want 0", i, in_ready);
      end
      tick();
      n_chk++;
      if (lane_valid !== 4'h0 || sel !== 2'd1) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got v=%b sel=%0d want 0 1",
                 i, lane_valid, sel);
      end
    end
    lane_full = '0;
    tick();
    n_chk++;
    if (lane_valid !== 4'b0010 || lane_data !== 32'h0000_2100) begin
      n_fail++;
      $display("FAIL bp_resume: got v=%b d=%h want 0010 00002100",
               lane_valid, lane_data);
    end
    send(8'h22);
    send(8'h23);
    send(8'h24);
    in_valid = 1'b1;
    in_data = 8'h25;
    lane_full = 4'b0100;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_other_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    lane_full = '0;
    n_chk++;
    if (lane_valid !== 4'b0010 || lane_data !== 32'h0000_2500) begin
      n_fail++;
      $display("FAIL bp_other_lane: got v=%b d=%h want 0010 00002500",
               lane_valid, lane_data);
    end
  endtask

  task automatic test_flush_accept_last();
    apply_reset();
    send(8'h50);
    send(8'h51);
    send(8'h52);
    in_valid = 1'b1;
    in_data = 8'h55;
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (lane_valid !== 4'b1000 || lane_data !== 32'h5500_0000
        || stripe_done !== 1'b1) begin
      n_fail++;
      $display("FAIL fl3_lane: got v=%b d=%h sd=%b want 1000 55000000 1",
               lane_valid, lane_data, stripe_done);
    end
    n_chk++;
    if (busy !== 1'b0 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL fl3_state: got busy=%b sel=%0d want 0 0", busy, sel);
    end
    tick();
    flush = 1'b0;
    n_chk++;
    if (lane_valid !== 4'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fl3_nopad: got v=%b busy=%b want 0 0", lane_valid, busy);
    end
  endtask

  task automatic test_flush_accept_mid();
    apply_reset();
    send(8'h60);
    in_valid = 1'b1;
    in_data = 8'h66;
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    n_chk++;
    if (lane_valid !== 4'b0010 || lane_data !== 32'h0000_6600
        || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fl1_lane: got v=%b d=%h busy=%b rdy=%b want 0010 00006600 1 0",
               lane_valid, lane_data, busy, in_ready);
    end
    tick();
    n_chk++;
    if (lane_valid !== 4'b0100 || lane_data !== 32'h00F7_0000) begin
      n_fail++;
      $display("FAIL fl1_pad2: got v=%b d=%h want 0100 00f70000",
               lane_valid, lane_data);
    end
    tick();
    n_chk++;
    if (lane_valid !== 4'b1000 || lane_data !== 32'hF700_0000
        || stripe_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fl1_pad3: got v=%b d=%h sd=%b busy=%b want 1000 f7000000 1 0",
               lane_valid, lane_data, stripe_done, busy);
    end
  endtask

  task automatic test_reset_in_pad();
    apply_reset();
    for (int i = 0; i < 6; i++) send(8'h70 + 8'(i));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || stripe_cnt !== 16'd1 || sel !== 2'd2) begin
      n_fail++;
      $display("FAIL rpad_pre: got busy=%b cnt=%0d sel=%0d want 1 1 2",
               busy, stripe_cnt, sel);
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (lane_valid !== 4'h0 || lane_data !== 32'h0 || sel !== 2'd0
        || busy !== 1'b0 || in_ready !== 1'b0 || stripe_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rpad_async: got v=%b d=%h sel=%0d busy=%b rdy=%b cnt=%0d want 0",
               lane_valid, lane_data, sel, busy, in_ready, stripe_cnt);
    end
    tick();
    tick();
    n_chk++;
    if (lane_valid !== 4'h0 || lane_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rpad_nowrite: got v=%b d=%h want 0", lane_valid, lane_data);
    end
    reset = 1'b1;
    send(8'h77);
    n_chk++;
    if (lane_valid !== 4'b0001 || lane_data !== 32'h0000_0077
        || stripe_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rpad_first: got v=%b d=%h cnt=%0d want 0001 00000077 0",
               lane_valid, lane_data, stripe_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    apply_reset();
    force dut.stripe_cnt = 16'hFFFE;
    #1;
    release dut.stripe_cnt;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(i);
      tick();
      if (i == 3) begin
        n_chk++;
        if (stripe_cnt !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL wrap_ffff: got %h want ffff", stripe_cnt);
        end
      end
    end
    in_valid = 1'b0;
    n_chk++;
    if (stripe_cnt !== 16'h0000 || stripe_done !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_zero: got cnt=%h sd=%b want 0000 1",
               stripe_cnt, stripe_done);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_flush_pad();
    test_backpressure();
    test_flush_accept_last();
    test_flush_accept_mid();
    test_reset_in_pad();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
